// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared funct3 encodings, FSM state type and width helpers for the LSU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    function automatic logic is_byte(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_BU);
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    // Anything that is neither byte nor halfword (incl. 011/110/111) is a word access.
    function automatic logic is_word(input logic [2:0] f3);
        return !is_byte(f3) && !is_half(f3);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational byte-lane logic: store strobes/replication, load extract/extend.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offs,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shifted = rdata >> {offs, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = offs[1] ? rdata[31:16] : rdata[15:0];

    // funct3[2] set means the unsigned variant (LBU/LHU).
    always_comb begin
        wstrb     = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        if (is_byte(funct3)) begin
            wstrb     = 4'b0001 << offs;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{w_byte[7] & ~funct3[2]}}, w_byte};
        end else if (is_half(funct3)) begin
            wstrb     = offs[1] ? 4'b1100 : 4'b0011;
            wdata     = {2{store_data[15:0]}};
            load_data = {{16{w_half[15] & ~funct3[2]}}, w_half};
        end
    end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
// Module   : lsu
// Brief    : RV32I load/store unit driving a single-beat valid/ready data bus.
//            Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu
    import lsu_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [31:0]       base,
    input  logic [31:0]       offset,
    input  logic [31:0]       store_data,
    output logic [31:0]       load_result,
    output logic              done,
    output logic              err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e  r_state;
    lsu_state_e  w_state_nxt;
    logic [31:0] r_ea;
    logic [31:0] r_store_data;
    logic [31:0] r_load_result;
    logic [31:0] r_cnt;
    logic [2:0]  r_funct3;
    logic        r_is_load;
    logic        r_err;

    logic [31:0] w_ea;
    logic        w_is_mem;
    logic        w_misalign;
    logic        w_timeout;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    assign w_ea     = base + offset;
    assign w_is_mem = is_load || is_store;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = (is_half(funct3) && w_ea[0]) ||
                        (is_word(funct3) && (w_ea[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Fires on the wait cycle that would bring the counter up to BUS_TIMEOUT.
    assign w_timeout = (BUS_TIMEOUT != 0) && !mem_ready &&
                       ((r_cnt + 32'd1) == 32'(BUS_TIMEOUT));

    lsu_align u_align (
        .funct3     (r_funct3),
        .offs       (r_ea[1:0]),
        .store_data (r_store_data),
        .rdata      (mem_rdata),
        .wstrb      (w_wstrb),
        .wdata      (w_wdata),
        .load_data  (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (!w_is_mem || w_misalign) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_ready || w_timeout) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ea          <= '0;
            r_store_data  <= '0;
            r_load_result <= '0;
            r_cnt         <= '0;
            r_funct3      <= '0;
            r_is_load     <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_ea         <= w_ea;
                r_funct3     <= funct3;
                r_is_load    <= is_load;
                r_store_data <= store_data;
                r_cnt        <= '0;
                r_err        <= w_is_mem && w_misalign;
            end else if (r_state == REQ) begin
                if (mem_ready) begin
                    if (r_is_load) begin
                        r_load_result <= w_load_data;
                    end
                end else begin
                    r_cnt <= r_cnt + 32'd1;
                    if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign done        = (r_state == RESP);
    assign err         = done && r_err;
    assign load_result = r_load_result;
    assign mem_valid   = (r_state == REQ);
    assign mem_addr    = {r_ea[ADDR_W-1:2], 2'b00};
    assign mem_we      = mem_valid && !r_is_load;
    assign mem_wstrb   = mem_we ? w_wstrb : 4'b0000;
    assign mem_wdata   = mem_we ? w_wdata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
// Module   : tb_lsu
// Brief    : Scoreboard bench for lsu: bus-side checks per cycle, results checked on done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu;
    import lsu_pkg::*;

    localparam int c_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] base = '0;
    logic [31:0] offset = '0;
    logic [31:0] store_data = '0;
    logic [31:0] load_result;
    logic        done;
    logic        err;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    typedef struct packed {
        logic        err;
        logic [31:0] res;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = '0;

    lsu #(
        .BUS_TIMEOUT (c_TIMEOUT),
        .ADDR_W      (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_load     (is_load),
        .is_store    (is_store),
        .funct3      (funct3),
        .base        (base),
        .offset      (offset),
        .store_data  (store_data),
        .load_result (load_result),
        .done        (done),
        .err         (err),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wstrb   (mem_wstrb),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Result side of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("err", 32'(err), 32'(e.err));
                check("load_result", load_result, e.res);
            end
        end
    end

    // n_valid: number of cycles mem_valid must be high; done follows one cycle later.
    task automatic run_op(input string name, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] b, input logic [31:0] o,
                          input logic [31:0] sd, input logic [31:0] rd, input int waits,
                          input int n_valid, input logic [31:0] e_addr, input logic [3:0] e_strb,
                          input logic [31:0] e_wdata, input logic e_err, input logic [31:0] e_res);
        bit got_done = 0;
        sb_q.push_back('{err: e_err, res: e_res});
        @(posedge clk); #1;
        start = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        base = b; offset = o; store_data = sd; mem_rdata = rd; mem_ready = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            mem_ready = (k == waits + 1);
            @(negedge clk);
            if (done) begin
                check({name, "_latency"}, 32'(k), 32'(n_valid + 1));
                got_done = 1;
                break;
            end
            check({name, "_valid"}, 32'(mem_valid), 32'(k <= n_valid));
            if (k <= n_valid) begin
                check({name, "_addr"}, mem_addr, e_addr);
                check({name, "_we"}, 32'(mem_we), 32'(st && !ld));
                check({name, "_wstrb"}, 32'(mem_wstrb), 32'(e_strb));
                if (st && !ld) check({name, "_wdata"}, mem_wdata, e_wdata);
            end
        end
        mem_ready = 1'b0;
        if (!got_done) check({name, "_done_seen"}, 32'd0, 32'd1);
        last_res = e_res;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_load_result", load_result, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op("lw", 1, 0, F3_W, 32'h100, 32'd4, 32'h0, 32'hDEADBEEF, 0, 1,
               32'h104, 4'b0000, 32'h0, 0, 32'hDEADBEEF);
        run_op("lb", 1, 0, F3_B, 32'h200, 32'd3, 32'h0, 32'h80FF1234, 0, 1,
               32'h200, 4'b0000, 32'h0, 0, 32'hFFFFFF80);
        run_op("lbu", 1, 0, F3_BU, 32'h200, 32'd3, 32'h0, 32'h80FF1234, 1, 2,
               32'h200, 4'b0000, 32'h0, 0, 32'h00000080);
        run_op("sh", 0, 1, F3_H, 32'h0, 32'd2, 32'h0000ABCD, 32'h0, 3, 4,
               32'h0, 4'b1100, 32'hABCDABCD, 0, last_res);
        run_op("lh", 1, 0, F3_H, 32'h200, 32'd2, 32'h0, 32'h80FF1234, 0, 1,
               32'h200, 4'b0000, 32'h0, 0, 32'hFFFF80FF);
        run_op("lhu", 1, 0, F3_HU, 32'h210, 32'hFFFFFFF0, 32'h0, 32'h80FF1234, 0, 1,
               32'h200, 4'b0000, 32'h0, 0, 32'h00001234);
        run_op("sb", 0, 1, F3_B, 32'h300, 32'd1, 32'h123456A5, 32'h0, 0, 1,
               32'h300, 4'b0010, 32'hA5A5A5A5, 0, last_res);
        run_op("sw", 0, 1, F3_W, 32'h400, 32'd0, 32'hCAFEF00D, 32'h0, 2, 3,
               32'h400, 4'b1111, 32'hCAFEF00D, 0, last_res);
        run_op("nop", 0, 0, F3_W, 32'h500, 32'd0, 32'h0, 32'h0, 0, 0,
               32'h0, 4'b0000, 32'h0, 0, last_res);
        run_op("timeout", 1, 0, F3_W, 32'h600, 32'd0, 32'h0, 32'h77777777, 1000, c_TIMEOUT,
               32'h600, 4'b0000, 32'h0, 1, last_res);
`ifdef LSU_MISALIGN_TRAP_EN
        run_op("misalign", 1, 0, F3_W, 32'h100, 32'd1, 32'h0, 32'h11223344, 0, 0,
               32'h0, 4'b0000, 32'h0, 1, last_res);
`else
        run_op("misalign", 1, 0, F3_W, 32'h100, 32'd1, 32'h0, 32'h11223344, 0, 1,
               32'h100, 4'b0000, 32'h0, 0, 32'h11223344);
`endif
        run_op("f3_undef", 1, 0, 3'b011, 32'h8, 32'd0, 32'h0, 32'h55AA00FF, 0, 1,
               32'h8, 4'b0000, 32'h0, 0, 32'h55AA00FF);

        // Abort a load in REQ with an asynchronous reset.
        @(posedge clk); #1;
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = F3_W;
        base = 32'h40; offset = 32'h0; mem_ready = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        check("abort_pre_valid", 32'(mem_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_async_valid", 32'(mem_valid), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        check("abort_done_held", 32'(done), 32'd0);
        check("abort_load_result", load_result, 32'd0);
        rst_n = 1'b1;
        last_res = 32'h0;
        run_op("post_rst", 1, 0, F3_W, 32'h20, 32'd0, 32'h0, 32'h0BADF00D, 0, 1,
               32'h20, 4'b0000, 32'h0, 0, 32'h0BADF00D);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
